// File: rtl/sap_pkg.sv
// sap_pkg: shared definitions for the SAP register bank and its debug scanner.
//   SAP_WIDTH  - default register / bus width
//   sap_op_e   - write operations, listed from highest to lowest priority
//   sap_addr_w - select width for an n-entry array (at least 1 bit)
package sap_pkg;

  localparam int SAP_WIDTH = 8;

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_CLEAR = 3'd1,
    OP_LOAD  = 3'd2,
    OP_INC   = 3'd3,
    OP_DEC   = 3'd4
  } sap_op_e;

  function automatic int sap_addr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sap_register_bank_if.sv
// sap_register_bank_if: SAP bus bundle for the register bank.
//   write side : bus_in, wr_sel, load, clear, inc, dec
//   read side  : rd_sel, oe -> bus_out, bus_valid
//   flags      : zero, carry
//   debug      : debug_idx, debug_out
// master drives the control inputs; slave is the register bank.
interface sap_register_bank_if
  import sap_pkg::*;
#(
  parameter int WIDTH = SAP_WIDTH,
  parameter int NREGS = 4
);
  localparam int ADDR_W = sap_addr_w(NREGS);

  logic [WIDTH-1:0]  bus_in;
  logic [ADDR_W-1:0] wr_sel;
  logic              load;
  logic              clear;
  logic              inc;
  logic              dec;
  logic [ADDR_W-1:0] rd_sel;
  logic              oe;
  logic [WIDTH-1:0]  bus_out;
  logic              bus_valid;
  logic              zero;
  logic              carry;
  logic [ADDR_W-1:0] debug_idx;
  logic [WIDTH-1:0]  debug_out;

  modport master (
    output bus_in, wr_sel, load, clear, inc, dec, rd_sel, oe,
    input  bus_out, bus_valid, zero, carry, debug_idx, debug_out
  );

  modport slave (
    input  bus_in, wr_sel, load, clear, inc, dec, rd_sel, oe,
    output bus_out, bus_valid, zero, carry, debug_idx, debug_out
  );

endinterface

// File: rtl/sap_scan_counter.sv
// sap_scan_counter: free-running debug scanner for SAP display muxes.
// Counts SCAN_DIV clocks per step; each terminal count advances debug_idx,
// wrapping NREGS-1 -> 0.
//   clk       in   system clock
//   reset     in   synchronous active-high reset (counter and index to 0)
//   debug_idx out  entry currently selected for display
module sap_scan_counter
  import sap_pkg::*;
#(
  parameter int SCAN_DIV = 27000000,
  parameter int NREGS    = 4,
  localparam int ADDR_W  = sap_addr_w(NREGS)
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] debug_idx
);

  localparam int CNT_W = sap_addr_w(SCAN_DIV);

  logic [CNT_W-1:0] cnt;
  logic             tc;

  assign tc = (cnt == CNT_W'(SCAN_DIV - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= '0;
      debug_idx <= '0;
    end else if (tc) begin
      cnt       <= '0;
      debug_idx <= (debug_idx == ADDR_W'(NREGS - 1)) ? '0 : debug_idx + ADDR_W'(1);
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/sap_register_bank.sv
// sap_register_bank: NREGS x WIDTH register bank on the shared SAP bus.
// Each cycle at most one register (wr_sel) is written, priority
// clear > load > (inc&dec: no-op) > inc > dec, modulo 2^WIDTH.
// zero/carry reflect the last effective write. Reads are registered with
// one cycle of latency; bus_valid follows oe. A scan counter walks
// debug_idx across the registers for the LED display.
//   clk, reset : system clock, synchronous active-high reset
//   bus        : sap_register_bank_if.slave (all data/control/flag/debug)
// Build option: SAP_BANK_BYPASS_EN forwards a same-cycle write to the read
// port; without it a colliding read returns the pre-write value.
module sap_register_bank
  import sap_pkg::*;
#(
  parameter int WIDTH    = SAP_WIDTH,
  parameter int NREGS    = 4,
  parameter int SCAN_DIV = 27000000
) (
  input  logic                 clk,
  input  logic                 reset,
  sap_register_bank_if.slave   bus
);

  localparam int ADDR_W = sap_addr_w(NREGS);

  logic [NREGS-1:0][WIDTH-1:0] regs;

  sap_op_e          op;
  logic             wr_hit;
  logic             wr_en;
  logic             wrap;
  logic [WIDTH-1:0] cur;
  logic [WIDTH-1:0] wr_val;
  logic             rd_hit;
  logic [WIDTH-1:0] rd_val;
  logic [ADDR_W-1:0] debug_idx;

  // op decode and next value for reg[wr_sel]
  always_comb begin
    op = OP_NONE;
    if (bus.clear)                 op = OP_CLEAR;
    else if (bus.load)             op = OP_LOAD;
    else if (bus.inc && bus.dec)   op = OP_NONE;
    else if (bus.inc)              op = OP_INC;
    else if (bus.dec)              op = OP_DEC;

    // select can exceed NREGS only when NREGS is not a power of two
    wr_hit = (int'(bus.wr_sel) < NREGS);
    cur    = wr_hit ? regs[bus.wr_sel] : '0;
    wr_val = cur;
    wrap   = 1'b0;
    case (op)
      OP_CLEAR: wr_val = '0;
      OP_LOAD:  wr_val = bus.bus_in;
      OP_INC: begin
        wr_val = cur + WIDTH'(1);
        wrap   = &cur;
      end
      OP_DEC: begin
        wr_val = cur - WIDTH'(1);
        wrap   = ~|cur;
      end
      default: ;
    endcase
    wr_en = wr_hit && (op != OP_NONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      regs <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < NREGS; i++)
        if (bus.wr_sel == ADDR_W'(i)) regs[i] <= wr_val;
    end
  end

  // flags only move on an effective write
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.zero  <= 1'b0;
      bus.carry <= 1'b0;
    end else if (wr_en) begin
      bus.zero  <= (wr_val == '0);
      bus.carry <= wrap;
    end
  end

  // read port
  always_comb begin
    rd_hit = (int'(bus.rd_sel) < NREGS);
    rd_val = rd_hit ? regs[bus.rd_sel] : '0;
`ifdef SAP_BANK_BYPASS_EN
    if (wr_en && rd_hit && (bus.wr_sel == bus.rd_sel)) rd_val = wr_val;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.bus_out   <= '0;
      bus.bus_valid <= 1'b0;
    end else begin
      bus.bus_out   <= bus.oe ? rd_val : '0;
      bus.bus_valid <= bus.oe;
    end
  end

  // debug scan
  sap_scan_counter #(
    .SCAN_DIV (SCAN_DIV),
    .NREGS    (NREGS)
  ) u_scan (
    .clk       (clk),
    .reset     (reset),
    .debug_idx (debug_idx)
  );

  assign bus.debug_idx = debug_idx;
  assign bus.debug_out = regs[debug_idx];

endmodule

// File: tb/tb_sap_register_bank.sv
// Directed bench for sap_register_bank (WIDTH=8, NREGS=4, SCAN_DIV=3).
module tb_sap_register_bank;

  logic clk;
  logic reset;
  int   vectors    = 0;
  int   miscompares = 0;
  logic [7:0] exp_byp;

  sap_register_bank_if #(.WIDTH(8), .NREGS(4)) bus ();

  sap_register_bank #(
    .WIDTH    (8),
    .NREGS    (4),
    .SCAN_DIV (3)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.bus_in = '0; bus.wr_sel = '0; bus.load = 0; bus.clear = 0;
    bus.inc = 0; bus.dec = 0; bus.rd_sel = '0; bus.oe = 0;
  endtask

  task automatic rd(input logic [1:0] sel, input logic [7:0] exp, input string tag);
    idle();
    bus.oe = 1; bus.rd_sel = sel;
    tick();
    chk(tag, bus.bus_out, exp);
    chk({tag, "_valid"}, bus.bus_valid, 1);
  endtask

  initial begin
    idle();
    reset = 1;
    tick(); tick();
    chk("rst_bus_out", bus.bus_out, 0);
    chk("rst_valid", bus.bus_valid, 0);
    chk("rst_zero", bus.zero, 0);
    chk("rst_carry", bus.carry, 0);
    chk("rst_dbg_idx", bus.debug_idx, 0);
    chk("rst_dbg_out", bus.debug_out, 0);
    reset = 0;

    // load then read back with one-cycle latency
    bus.load = 1; bus.wr_sel = 2; bus.bus_in = 8'h5A;
    tick();
    rd(2, 8'h5A, "rd_5a");
    chk("rd_5a_zero", bus.zero, 0);
    chk("rd_5a_carry", bus.carry, 0);

    // wrap behaviour on reg1
    idle(); bus.load = 1; bus.wr_sel = 1; bus.bus_in = 8'hFF;
    tick();
    chk("oe0_bus_out", bus.bus_out, 0);
    chk("oe0_valid", bus.bus_valid, 0);
    idle(); bus.inc = 1; bus.wr_sel = 1;
    tick();
    chk("inc_wrap_zero", bus.zero, 1);
    chk("inc_wrap_carry", bus.carry, 1);
    idle(); bus.dec = 1; bus.wr_sel = 1;
    tick();
    chk("dec_wrap_zero", bus.zero, 0);
    chk("dec_wrap_carry", bus.carry, 1);
    rd(1, 8'hFF, "rd_dec_wrap");
    idle(); bus.load = 1; bus.wr_sel = 1; bus.bus_in = 8'h03;
    tick();
    chk("load_clr_carry", bus.carry, 0);
    chk("load_zero", bus.zero, 0);
    rd(1, 8'h03, "rd_03");

    // priority: clear beats load and inc
    idle(); bus.load = 1; bus.wr_sel = 0; bus.bus_in = 8'h07;
    tick();
    idle(); bus.clear = 1; bus.load = 1; bus.inc = 1; bus.wr_sel = 0; bus.bus_in = 8'hAA;
    tick();
    chk("prio_zero", bus.zero, 1);
    rd(0, 8'h00, "rd_prio");
    idle(); bus.load = 1; bus.wr_sel = 3; bus.bus_in = 8'h10;
    tick();
    chk("ld10_zero", bus.zero, 0);
    idle(); bus.clear = 1; bus.wr_sel = 0;
    tick();
    chk("clr_zero", bus.zero, 1);
    // inc+dec together: no write, flags hold
    idle(); bus.inc = 1; bus.dec = 1; bus.wr_sel = 3;
    tick();
    chk("incdec_zero_hold", bus.zero, 1);
    chk("incdec_carry_hold", bus.carry, 0);
    rd(3, 8'h10, "rd_incdec");

    // read/write collision
    idle(); bus.load = 1; bus.wr_sel = 2; bus.bus_in = 8'h11;
    tick();
    idle(); bus.load = 1; bus.wr_sel = 2; bus.bus_in = 8'h22; bus.oe = 1; bus.rd_sel = 2;
    tick();
`ifdef SAP_BANK_BYPASS_EN
    exp_byp = 8'h22;
`else
    exp_byp = 8'h11;
`endif
    chk("collide", bus.bus_out, exp_byp);
    rd(2, 8'h22, "rd_after_collide");

    // debug scan from a fresh reset; reg1 loaded mid-scan
    idle(); reset = 1;
    tick();
    reset = 0;
    chk("scan_idx0", bus.debug_idx, 0);
    for (int k = 1; k <= 12; k++) begin
      idle();
      if (k == 4) begin bus.load = 1; bus.wr_sel = 1; bus.bus_in = 8'hC3; end
      tick();
      chk($sformatf("scan_idx_%0d", k), bus.debug_idx, (k / 3) % 4);
      chk($sformatf("scan_out_%0d", k), bus.debug_out,
          (k >= 4 && ((k / 3) % 4) == 1) ? 8'hC3 : 8'h00);
    end

    // reset while inc is held
    idle(); bus.load = 1; bus.wr_sel = 1; bus.bus_in = 8'h40;
    tick();
    idle(); bus.inc = 1; bus.wr_sel = 1; bus.oe = 1; bus.rd_sel = 1;
    tick();
    chk("pre_rst_rd", bus.bus_out, 8'h40);
    reset = 1;
    tick();
    chk("mid_rst_valid", bus.bus_valid, 0);
    chk("mid_rst_bus_out", bus.bus_out, 0);
    chk("mid_rst_idx", bus.debug_idx, 0);
    chk("mid_rst_dbg_out", bus.debug_out, 0);
    chk("mid_rst_carry", bus.carry, 0);
    reset = 0;
    tick();
    chk("post_rst_rd0", bus.bus_out, 8'h00);
    chk("post_rst_valid", bus.bus_valid, 1);
    tick();
    chk("post_rst_rd1", bus.bus_out, 8'h01);
    chk("post_rst_zero", bus.zero, 0);
    rd(1, 8'h02, "post_rst_rd2");
    rd(2, 8'h00, "post_rst_r2");
    rd(3, 8'h00, "post_rst_r3");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sap_register_bank.md
Name: sap_register_bank

Overview:
Parametrised successor to the single SAP register. Holds NREGS registers of WIDTH bits on the shared SAP bus and gives each register load, clear, increment, decrement and output-enable operations. Provides a registered bus read port with a valid strobe. A free-running debug scanner cycles through the registers so the LED display can show every register in turn.

Parameters:
WIDTH, 8, bit width of each register and of the bus
NREGS, 4, number of registers (2..16)
ADDR_W, $clog2(NREGS), register select width (derived; do not override)
SCAN_DIV, 27000000, clk cycles per debug-scan step (>=1)

Ports:
clk  in  1  system clock; all logic on posedge
reset  in  1  synchronous, active-high reset
bus_in  in  WIDTH  bus data for load
wr_sel  in  ADDR_W  target register for load/clear/inc/dec
load  in  1  write bus_in into reg[wr_sel]
clear  in  1  zero reg[wr_sel]
inc  in  1  reg[wr_sel] += 1
dec  in  1  reg[wr_sel] -= 1
rd_sel  in  ADDR_W  register driven onto bus_out
oe  in  1  output enable
bus_out  out  WIDTH  registered read data
bus_valid  out  1  bus_out holds valid data this cycle
zero  out  1  registered; last written value was zero
carry  out  1  registered; last inc wrapped max->0 or last dec wrapped 0->max
debug_idx  out  ADDR_W  register currently shown on debug_out
debug_out  out  WIDTH  live (combinational) value of reg[debug_idx]

Behaviour:
- Reset (reset=1 at posedge):
  - all registers, bus_out, bus_valid, zero, carry and debug_idx go to 0; scan counter goes to 0.
  - reset overrides every other input in that cycle.
- Write priority on reg[wr_sel], one cycle, highest first:
  - clear -> 0
  - load -> bus_in
  - inc and dec both set -> no change
  - inc -> +1
  - dec -> -1
- Arithmetic: modulo 2^WIDTH; 8'hFF+1 = 8'h00 and 8'h00-1 = 8'hFF.
- Flags update only in cycles where a write op (clear/load/inc/dec) takes effect:
  - zero = (new value == 0).
  - carry = 1 only on an inc/dec wrap; cleared by any other effective write.
  - Flags hold otherwise.
- wr_sel >= NREGS (non-power-of-2 NREGS): the write is ignored and flags hold.
- Read:
  - oe=1 at posedge N -> bus_out = reg[rd_sel] (value before the edge-N write) and bus_valid=1 after edge N. Latency is 1 cycle.
  - oe=0 -> bus_valid=0 and bus_out = 0.
  - rd_sel >= NREGS -> bus_out = 0 with bus_valid=1.
- Simultaneous write and read of the same register: read returns the old value (see optional feature).
- Debug scan:
  - The scan counter counts 0..SCAN_DIV-1.
  - At terminal count the counter returns to 0 and debug_idx advances by 1, wrapping NREGS-1 -> 0.
- Reset mid-operation: any pending op is dropped; there is no partial state.

Optional Feature:
- Macro SAP_BANK_BYPASS_EN.
- When defined: if oe and an effective write target the same register in one cycle, bus_out gets the post-write value (write-through forwarding).
- When undefined: bus_out gets the pre-write value, as specified above.
- All other behaviour is identical in both builds.

Decomposition:
- Shared package sap_pkg holds:
  - default SAP_WIDTH=8
  - op priority constants (OP_CLEAR, OP_LOAD, OP_INC, OP_DEC)
  - width helper for ADDR_W
- One sub-module, sap_scan_counter (parameters SCAN_DIV, NREGS; outputs debug_idx), which is reusable for other SAP debug muxes.
- Register array, op decode and read port stay in the top module.

Test Plan:
- reset, then load wr_sel=2 bus_in=8'h5A, then oe rd_sel=2 -> next cycle bus_out=8'h5A, bus_valid=1, zero=0.
- load reg1=8'hFF, then inc reg1 -> reg1=8'h00, zero=1, carry=1; then dec reg1 -> 8'hFF, carry=1; then load 8'h03 -> carry=0.
- clear+load+inc same cycle on reg0 holding 8'h07 -> reg0=0, zero=1; inc+dec together on reg3=8'h10 -> stays 8'h10, flags unchanged.
- load reg2=8'h11, then load 8'h22 with oe rd_sel=2 in the same cycle -> bus_out=8'h11 without SAP_BANK_BYPASS_EN, 8'h22 with it.
- SCAN_DIV=3, NREGS=4 -> debug_idx steps 0,1,2,3,0 every 3 cycles; debug_out tracks a register loaded mid-scan on the same cycle.
- assert reset while inc is held on reg1=8'h40 -> all regs 0, bus_valid=0, debug_idx=0; inc resumes from 0 after reset deasserts.
